// File: rtl/reg_bus_master.sv
// reg_bus_master
//   Initiator for the simple register bus. Accepts one command at a time on a
//   valid/ready port, issues exactly one bus access (write or read strobe),
//   captures read data RD_LATENCY cycles after the read strobe, and returns a
//   response on a valid/ready port. No command overlap: o_cmd_ready stays low
//   from accept until the response handshake completes.
//
//   Optional feature (macro REG_BUS_MASTER_RDCHK_EN): every write is followed
//   by a read-back of the same address; the read-back data is returned in
//   o_rsp_rdata and o_rsp_err flags bits that differ from the written data
//   under the command's vmask. With the macro undefined i_cmd_vmask is
//   ignored, o_rsp_err is 0 and writes respond with o_rsp_rdata = 0.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready command handshake
//   i_cmd_write/addr/wdata  command type, address, write data
//   i_cmd_vmask             read-back compare mask (feature only)
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_write/rdata/err   response type echo, read data, read-back mismatch
//   o_write/o_read          bus strobes (registered, one cycle each)
//   o_addr/o_wdata          bus address / write data (held between commands)
//   i_rdata                 bus read data from the responder
//   o_busy                  high whenever not idle
module reg_bus_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  input  logic [DATA_W-1:0] i_cmd_vmask,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic              o_rsp_write,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_write,
  output logic              o_read,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_busy
);

  localparam int              CNT_W    = $clog2(RD_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE  = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] RSP    = 3'd3;
`ifdef REG_BUS_MASTER_RDCHK_EN
  localparam logic [2:0] VISSUE = 3'd4;
  localparam logic [2:0] VWAIT  = 3'd5;
`endif

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;

`ifdef REG_BUS_MASTER_RDCHK_EN
  logic [DATA_W-1:0] vmask_q;
  logic              err_q;

  assign o_rsp_err = err_q;
`else
  logic unused_vmask;

  assign unused_vmask = ^i_cmd_vmask;
  assign o_rsp_err    = 1'b0;
`endif

  assign o_cmd_ready = (state == IDLE);
  assign o_rsp_valid = (state == RSP);
  assign o_busy      = (state != IDLE);

  // Strobes are flops loaded together with the state transition into the
  // issue states, so they are glitch-free and clear asynchronously on reset.
  // o_rsp_write doubles as the latched command type.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      o_write     <= 1'b0;
      o_read      <= 1'b0;
      o_addr      <= '0;
      o_wdata     <= '0;
      o_rsp_rdata <= '0;
      o_rsp_write <= 1'b0;
`ifdef REG_BUS_MASTER_RDCHK_EN
      vmask_q     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        // accept one command; clear the response fields for the new access
        IDLE: begin
          if (i_cmd_valid) begin
            state       <= ISSUE;
            o_rsp_write <= i_cmd_write;
            o_addr      <= i_cmd_addr;
            o_wdata     <= i_cmd_wdata;
            o_rsp_rdata <= '0;
            o_write     <= i_cmd_write;
            o_read      <= ~i_cmd_write;
`ifdef REG_BUS_MASTER_RDCHK_EN
            vmask_q     <= i_cmd_vmask;
            err_q       <= 1'b0;
`endif
          end
        end
        // single strobe cycle
        ISSUE: begin
          o_write <= 1'b0;
          o_read  <= 1'b0;
          if (o_rsp_write) begin
`ifdef REG_BUS_MASTER_RDCHK_EN
            o_read <= 1'b1;
            state  <= VISSUE;
`else
            state  <= RSP;
`endif
          end else begin
            cnt   <= CNT_LOAD;
            state <= WAIT;
          end
        end
        // count down the responder latency; sample on the last count
        WAIT: begin
          if (cnt == CNT_LAST) begin
            o_rsp_rdata <= i_rdata;
            state       <= RSP;
          end else begin
            cnt <= cnt - CNT_LAST;
          end
        end
`ifdef REG_BUS_MASTER_RDCHK_EN
        // read-back strobe of the address just written
        VISSUE: begin
          o_read <= 1'b0;
          cnt    <= CNT_LOAD;
          state  <= VWAIT;
        end
        // read-back capture and masked compare against the written data
        VWAIT: begin
          if (cnt == CNT_LAST) begin
            o_rsp_rdata <= i_rdata;
            err_q       <= |((i_rdata ^ o_wdata) & vmask_q);
            state       <= RSP;
          end else begin
            cnt <= cnt - CNT_LAST;
          end
        end
`endif
        // response held until consumed
        RSP: begin
          if (i_rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
`timescale 1ns/1ps
module tb_reg_bus_master;

`ifdef REG_BUS_MASTER_RDCHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cmd_valid, cmd_valid3, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata, cmd_vmask;
  logic        rsp_ready, rsp_ready3;
  logic [31:0] rdata, rdata3;

  logic        cmd_ready, rsp_valid, rsp_write, rsp_err, bus_write, bus_read, busy;
  logic [31:0] rsp_rdata, bus_addr, bus_wdata;
  logic        cmd_ready3, rsp_valid3, rsp_write3, rsp_err3, bus_write3, bus_read3, busy3;
  logic [31:0] rsp_rdata3, bus_addr3, bus_wdata3;

  reg_bus_master #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_vmask(cmd_vmask),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_write(rsp_write),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_write(bus_write), .o_read(bus_read), .o_addr(bus_addr), .o_wdata(bus_wdata),
    .i_rdata(rdata), .o_busy(busy)
  );

  reg_bus_master #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid3), .o_cmd_ready(cmd_ready3), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_vmask(cmd_vmask),
    .o_rsp_valid(rsp_valid3), .i_rsp_ready(rsp_ready3), .o_rsp_write(rsp_write3),
    .o_rsp_rdata(rsp_rdata3), .o_rsp_err(rsp_err3),
    .o_write(bus_write3), .o_read(bus_read3), .o_addr(bus_addr3), .o_wdata(bus_wdata3),
    .i_rdata(rdata3), .o_busy(busy3)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Responder environment: memory with per-write mask, garbage on i_rdata
  // except in the single cycle the data is due.
  logic [31:0] resp_mem [logic [31:0]];
  logic [31:0] rmask = 32'hFFFF_FFFF;
  logic [31:0] garbage = 32'h0BAD_0000;
  logic [31:0] rd_data = '0;
  int          rd_cyc = -10;
  int          rd3_cyc = -10;
  int          wr_cnt = 0, rd_cnt = 0, wr_cyc = -10;
  logic [31:0] wr_addr_s = '0, wr_data_s = '0, rd_addr_s = '0;

  always @(posedge clk) garbage <= {16'h0BAD, 16'($urandom)};

  always @(negedge clk) begin
    if (bus_write || bus_read) begin
      checks++;
      if (bus_write && bus_read) begin
        errors++;
        $display("FAIL strobe_overlap: write=%b read=%b at cycle %0d, required never both", bus_write, bus_read, cyc);
      end
    end
    if (bus_write) begin
      resp_mem[bus_addr] = bus_wdata & rmask;
      wr_cnt++;
      wr_cyc = cyc;
      wr_addr_s = bus_addr;
      wr_data_s = bus_wdata;
    end
    if (bus_read) begin
      rd_data = resp_mem.exists(bus_addr) ? resp_mem[bus_addr] : 32'h0;
      rd_cnt++;
      rd_cyc = cyc;
      rd_addr_s = bus_addr;
    end
    if (bus_read3) rd3_cyc = cyc;
  end

  assign rdata  = (cyc == rd_cyc + 1)  ? rd_data       : garbage;
  assign rdata3 = (cyc == rd3_cyc + 3) ? 32'hDEAD_BEEF : garbage;

  // Reference model: expected register contents after each write.
  logic [31:0] exp_mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : 32'h0;
  endfunction

  task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] m, input int hold, input string tag);
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_lat, n, t0, wr0, rd0, e_wr, e_rd;
    if (wr) begin
      exp_mem[a] = d & rmask;
      e_rdata = CHK ? (d & rmask) : 32'h0;
      e_err   = CHK ? |(((d & rmask) ^ d) & m) : 1'b0;
      e_lat   = CHK ? 4 : 2;
      e_wr    = 1;
      e_rd    = CHK ? 1 : 0;
    end else begin
      e_rdata = mem_rd(a);
      e_err   = 1'b0;
      e_lat   = 3;
      e_wr    = 0;
      e_rd    = 1;
    end
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_ready: cmd_ready=%b, required 1", tag, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_vmask = m;
    rsp_ready = (hold == 0);
    t0 = cyc;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      cmd_valid = 1'b0;
    end while (rsp_valid !== 1'b1 && n < 30);
    checks++;
    if (n !== e_lat) begin
      errors++;
      $display("FAIL %s latency: response after %0d cycles, required %0d", tag, n, e_lat);
    end
    checks++;
    if ({cmd_ready, rsp_write, rsp_err, rsp_rdata} !== {1'b0, wr, e_err, e_rdata}) begin
      errors++;
      $display("FAIL %s response: ready=%b write=%b err=%b rdata=%h, required ready=0 write=%b err=%b rdata=%h",
               tag, cmd_ready, rsp_write, rsp_err, rsp_rdata, wr, e_err, e_rdata);
    end
    checks++;
    if ((wr_cnt - wr0) !== e_wr || (rd_cnt - rd0) !== e_rd) begin
      errors++;
      $display("FAIL %s strobe_count: writes=%0d reads=%0d, required writes=%0d reads=%0d",
               tag, wr_cnt - wr0, rd_cnt - rd0, e_wr, e_rd);
    end
    checks++;
    if (wr) begin
      if (wr_cyc !== t0 + 1 || wr_addr_s !== a || wr_data_s !== d ||
          (CHK && (rd_cyc !== t0 + 2 || rd_addr_s !== a))) begin
        errors++;
        $display("FAIL %s write_strobe: cyc=%0d addr=%h data=%h rb_cyc=%0d, required cyc=%0d addr=%h data=%h",
                 tag, wr_cyc, wr_addr_s, wr_data_s, rd_cyc, t0 + 1, a, d);
      end
    end else begin
      if (rd_cyc !== t0 + 1 || rd_addr_s !== a) begin
        errors++;
        $display("FAIL %s read_strobe: cyc=%0d addr=%h, required cyc=%0d addr=%h",
                 tag, rd_cyc, rd_addr_s, t0 + 1, a);
      end
    end
    if (hold > 0) begin
      wr0 = wr_cnt;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h3C; cmd_wdata = 32'h5555_AAAA;
      repeat (hold) begin
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, cmd_ready, rsp_write, rsp_err, rsp_rdata} !== {1'b1, 1'b0, wr, e_err, e_rdata}) begin
          errors++;
          $display("FAIL %s hold: valid=%b ready=%b write=%b err=%b rdata=%h, required valid=1 ready=0 rdata=%h",
                   tag, rsp_valid, cmd_ready, rsp_write, rsp_err, rsp_rdata, e_rdata);
        end
      end
      checks++;
      if (wr_cnt !== wr0) begin
        errors++;
        $display("FAIL %s hold_accept: %0d strobes while response pending, required 0", tag, wr_cnt - wr0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    checks++;
    if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL %s after_handshake: ready=%b valid=%b busy=%b, required 1 0 0", tag, cmd_ready, rsp_valid, busy);
    end
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    checks++;
    if ({cmd_ready, rsp_valid, bus_write, bus_read, busy, rsp_err, rsp_write, rsp_rdata, bus_addr, bus_wdata}
        !== {1'b1, 6'b0, 96'b0}) begin
      errors++;
      $display("FAIL reset_values: ready=%b valid=%b wr=%b rd=%b busy=%b err=%b rw=%b rdata=%h addr=%h wdata=%h",
               cmd_ready, rsp_valid, bus_write, bus_read, busy, rsp_err, rsp_write, rsp_rdata, bus_addr, bus_wdata);
    end
    checks++;
    if ({cmd_ready3, rsp_valid3, busy3, bus_read3} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_values3: ready=%b valid=%b busy=%b rd=%b, required 1 0 0 0", cmd_ready3, rsp_valid3, busy3, bus_read3);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write;
    do_txn(1'b1, 32'h10, 32'hA5A5_0001, 32'hFFFF_FFFF, 0, "write");
  endtask

  task automatic test_read;
    resp_mem[32'h04] = 32'h1234_5678;
    exp_mem[32'h04]  = 32'h1234_5678;
    do_txn(1'b0, 32'h04, 32'h0, 32'h0, 0, "read");
  endtask

  task automatic test_latency3;
    int n;
    cmd_write = 1'b0; cmd_addr = 32'h20; cmd_valid3 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      cmd_valid3 = 1'b0;
    end while (rsp_valid3 !== 1'b1 && n < 30);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL lat3_latency: response after %0d cycles, required 5", n);
    end
    checks++;
    if ({rsp_write3, rsp_err3, rsp_rdata3} !== {2'b00, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL lat3_rdata: write=%b err=%b rdata=%h, required 0 0 deadbeef", rsp_write3, rsp_err3, rsp_rdata3);
    end
    @(posedge clk); #1;
    checks++;
    if ({cmd_ready3, rsp_valid3} !== 2'b10) begin
      errors++;
      $display("FAIL lat3_idle: ready=%b valid=%b, required 1 0", cmd_ready3, rsp_valid3);
    end
  endtask

  task automatic test_rsp_hold;
    do_txn(1'b0, 32'h04, 32'h0, 32'h0, 5, "rsp_hold");
  endtask

  task automatic test_reset_midop;
    cmd_write = 1'b0; cmd_addr = 32'h04; cmd_valid3 = 1'b1;
    @(posedge clk); #1;
    cmd_valid3 = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if ({bus_read, busy3, bus_read3} !== 3'b110) begin
      errors++;
      $display("FAIL midop_setup: read=%b busy3=%b read3=%b, required 1 1 0", bus_read, busy3, bus_read3);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_read, busy, cmd_ready, bus_read3, busy3, cmd_ready3} !== 6'b001001) begin
      errors++;
      $display("FAIL midop_async: read=%b busy=%b ready=%b read3=%b busy3=%b ready3=%b, required 0 0 1 0 0 1",
               bus_read, busy, cmd_ready, bus_read3, busy3, cmd_ready3);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_valid3, cmd_ready, cmd_ready3} !== 4'b0011) begin
        errors++;
        $display("FAIL midop_stale: valid=%b valid3=%b ready=%b ready3=%b, required 0 0 1 1",
                 rsp_valid, rsp_valid3, cmd_ready, cmd_ready3);
      end
    end
  endtask

  task automatic test_rdchk;
    rmask = 32'h0000_00FF;
    do_txn(1'b1, 32'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "rdchk_full");
    do_txn(1'b1, 32'h08, 32'hFFFF_FFFF, 32'h0000_00FF, 0, "rdchk_low");
    rmask = 32'hFFFF_FFFF;
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) begin
      rmask = ($urandom % 2) ? 32'hFFFF_FFFF : 32'h0000_00FF;
      do_txn(1'($urandom % 2), {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, $urandom,
             $urandom_range(0, 3), "random");
    end
    rmask = 32'hFFFF_FFFF;
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_valid3 = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_vmask = '0;
    rsp_ready = 1'b1; rsp_ready3 = 1'b1;
    test_reset;
    test_write;
    test_read;
    test_latency3;
    test_rsp_hold;
    test_reset_midop;
    test_rdchk;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
- Initiator for the team's simple register bus: write/read strobes, address, write data, registered read data.
- Takes single transactions from a valid/ready command port and drives exactly one bus access per command.
- Captures read data after a fixed responder latency and returns a response on a valid/ready port.
- Sits between a firmware/sequencer command source and any register-block responder.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width
RD_LATENCY, 1, cycles from the o_read strobe cycle to the first cycle i_rdata is valid; must be >=1

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_cmd_valid  input  1  command valid
o_cmd_ready  output  1  command accepted when high with i_cmd_valid
i_cmd_write  input  1  1=write, 0=read
i_cmd_addr  input  ADDR_W  target address
i_cmd_wdata  input  DATA_W  write data
i_cmd_vmask  input  DATA_W  read-back compare mask (used only with optional feature)
o_rsp_valid  output  1  response valid
i_rsp_ready  input  1  response consumed
o_rsp_write  output  1  echo of command type
o_rsp_rdata  output  DATA_W  read data (read-back data for verified writes, 0 otherwise)
o_rsp_err  output  1  read-back mismatch flag
o_write  output  1  bus write strobe
o_read  output  1  bus read strobe
o_addr  output  ADDR_W  bus address
o_wdata  output  DATA_W  bus write data
i_rdata  input  DATA_W  bus read data from responder
o_busy  output  1  high in any state other than IDLE

Behaviour:
- Clock/reset: one clock, i_clk. Reset is asynchronous, active-low (i_rst_n). Async assert forces IDLE immediately.
- Reset values:
  - o_cmd_ready=1 (IDLE).
  - o_rsp_valid, o_write, o_read, o_busy, o_rsp_err, o_rsp_write = 0.
  - o_addr, o_wdata, o_rsp_rdata = 0.
- Reset mid-operation: strobes drop asynchronously. The in-flight command is discarded and no response is produced.
- FSM states: IDLE, ISSUE, WAIT, RSP (plus VISSUE, VWAIT with feature).
- IDLE:
  - o_cmd_ready=1.
  - On i_cmd_valid&o_cmd_ready: latch write/addr/wdata/vmask, go to ISSUE.
- ISSUE:
  - Exactly one cycle with o_write=latched write and o_read=~latched write. Never both.
  - Write goes to RSP, with o_rsp_rdata=0 and o_rsp_err=0.
  - Read goes to WAIT and loads the latency counter with RD_LATENCY.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter reaches 1, capture i_rdata into o_rsp_rdata, then go to RSP.
  - With RD_LATENCY=1, WAIT lasts one cycle: strobe in cycle T, capture at the end of T+1.
- RSP:
  - o_rsp_valid=1. All o_rsp_* are held stable until i_rsp_ready, then go to IDLE.
  - o_rsp_valid is not dependent on i_rsp_ready.
- Bus signal rules:
  - o_addr/o_wdata are updated only on command accept and hold between commands.
  - o_write/o_read are decoded from state flops only (glitch-free) and are low outside ISSUE/VISSUE.
- Throughput:
  - Write with i_rsp_ready=1: accept T0, strobe T1, rsp T2, ready again T3.
  - Read adds RD_LATENCY cycles.
  - o_cmd_ready is low from accept until the response handshake completes. No command overlap.
- Response timing: i_rsp_ready high in the same cycle o_rsp_valid first rises completes the handshake in that cycle.

Optional Feature:
- Macro: REG_BUS_MASTER_RDCHK_EN.
- Defined:
  - After a write ISSUE, go to VISSUE: one-cycle o_read to the same o_addr.
  - Then go to VWAIT, which counts exactly like WAIT and captures i_rdata into o_rsp_rdata.
  - Then go to RSP with o_rsp_err = |((o_rsp_rdata ^ latched wdata) & latched vmask).
  - Reads are unaffected (o_rsp_err=0).
- Undefined: i_cmd_vmask is ignored, o_rsp_err is tied 0, and writes respond with o_rsp_rdata=0.

Test Plan:
- Reset, then write addr 0x10 data 0xA5A5_0001 with rsp_ready=1 -> o_write high exactly one cycle at T1 with o_addr=0x10, o_wdata=0xA5A5_0001; o_rsp_valid at T2, o_rsp_write=1, o_rsp_rdata=0.
- Responder model (RD_LATENCY=1) holding 0x1234_5678 at 0x04; read 0x04 -> o_read one cycle at T1; o_rsp_valid at T3 with o_rsp_rdata=0x1234_5678; o_write never asserted.
- RD_LATENCY=3, read returns 0xDEAD_BEEF only 3 cycles after strobe (garbage before) -> o_rsp_rdata=0xDEAD_BEEF, never the garbage value.
- Hold rsp_ready=0 for 5 cycles after a read response -> o_rsp_valid/o_rsp_rdata stable, o_cmd_ready=0, a new i_cmd_valid is not accepted until the cycle after the handshake.
- Assert i_rst_n=0 in WAIT of a read -> o_read/o_busy=0 immediately; after release o_cmd_ready=1 and no stale o_rsp_valid appears.
- RDCHK_EN, responder masks writes with 0x0000_00FF; write 0xFFFF_FFFF with vmask 0xFFFF_FFFF -> o_rsp_rdata=0x0000_00FF, o_rsp_err=1; same write with vmask 0x0000_00FF -> o_rsp_err=0.
